// File: rtl/detect_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : detect_window_ctrl_pkg
// Description : Shared state encodings and default widths for the window
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package detect_window_ctrl_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

endpackage : detect_window_ctrl_pkg
`default_nettype wire

// File: rtl/detect_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : detect_window_ctrl_if
// Description : Request/status bundle between a requester and the window
//               controller, including the detector start/match pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface detect_window_ctrl_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    logic             req;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             det_z;
    logic             det_start;
    logic             ack;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] match_cnt;
    logic             overflow;

    modport master (
        output req, len, abort, det_z,
        input  det_start, ack, busy, done, aborted, match_cnt, overflow
    );

    modport slave (
        input  req, len, abort, det_z,
        output det_start, ack, busy, done, aborted, match_cnt, overflow
    );

endinterface : detect_window_ctrl_if
`default_nettype wire

// File: rtl/detect_window_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Clearable saturating up-counter with sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
)(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_ovf
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    // Clear dominates increment so a new window always starts from zero.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc) begin
            if (r_cnt == c_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule : sat_counter
`default_nettype wire

// File: rtl/detect_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : detect_window_ctrl
// Description : Opens a start window of programmed length for the 1101
//               detector and reports a saturating count of its matches.
// Revision    : 1.0 - initial release
// ============================================================================
module detect_window_ctrl
    import detect_window_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
)(
    input  wire logic           clock,
    input  wire logic           reset,
    detect_window_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_remain;
    logic             r_ack;
    logic             r_aborted;

    logic             w_active;
    logic             w_accept;
    logic             w_abort;
    logic             w_det_start;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_match_cnt;
    logic             w_overflow;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_accept = (r_state == S_IDLE) && bus.req;
    assign w_abort  = w_active && bus.abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort is checked before the length/drain exits so it wins on the last bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_state_nxt = (bus.len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_remain == LEN_W'(1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = bus.abort ? S_IDLE : S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_det_start = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:  w_busy      = 1'b0;
            S_RUN:   w_det_start = 1'b1;
            S_DONE:  w_done      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_remain  <= '0;
            r_ack     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            if (w_accept) begin
                r_remain <= bus.len;
            end else if (r_state == S_RUN) begin
                r_remain <= r_remain - LEN_W'(1);
            end
            r_ack     <= w_accept && (bus.len != '0);
            r_aborted <= w_abort;
        end
    end

    // Matches seen during the drain cycle belong to the last window bit.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clock),
        .rst   (reset),
        .i_clr (w_accept),
        .i_inc (w_active && bus.det_z),
        .o_cnt (w_match_cnt),
        .o_ovf (w_overflow)
    );

    assign bus.det_start = w_det_start;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.ack       = r_ack;
    assign bus.aborted   = r_aborted;
    assign bus.match_cnt = w_match_cnt;
    assign bus.overflow  = w_overflow;

endmodule : detect_window_ctrl
`default_nettype wire

// File: tb/tb_detect_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_detect_window_ctrl
// Description : Randomised window-level checks of two controller instances
//               (8-bit and 2-bit match counters) against a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detect_window_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       req;
    logic [7:0] len;
    logic       abort;
    logic       det_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    detect_window_ctrl_if #(.LEN_W(8), .CNT_W(8)) if8 ();
    detect_window_ctrl_if #(.LEN_W(8), .CNT_W(2)) if2 ();

    assign if8.req   = req;
    assign if8.len   = len;
    assign if8.abort = abort;
    assign if8.det_z = det_z;
    assign if2.req   = req;
    assign if2.len   = len;
    assign if2.abort = abort;
    assign if2.det_z = det_z;

    detect_window_ctrl #(.LEN_W(8), .CNT_W(8)) u_dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (if8.slave)
    );

    detect_window_ctrl #(.LEN_W(8), .CNT_W(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (if2.slave)
    );

    // Status word layout: {busy, det_start, ack, done, aborted, overflow}
    task automatic test_reset();
        logic [5:0] st8, st2;
        reset = 1'b1; req = 1'b1; len = 8'd5; abort = 1'b0; det_z = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        st8 = {if8.busy, if8.det_start, if8.ack, if8.done, if8.aborted, if8.overflow};
        st2 = {if2.busy, if2.det_start, if2.ack, if2.done, if2.aborted, if2.overflow};
        n_checks += 2;
        if (st8 !== 6'b0 || if8.match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset8 got st=%b cnt=%0d want st=000000 cnt=0", st8, if8.match_cnt);
        end
        if (st2 !== 6'b0 || if2.match_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset2 got st=%b cnt=%0d want st=000000 cnt=0", st2, if2.match_cnt);
        end
        reset = 1'b0; req = 1'b0; det_z = 1'b0;
    endtask

    // Runs one window from an IDLE negedge; returns at the negedge of the
    // first IDLE cycle after it. zmode: 0 random, 1 all ones, 2 all zeros.
    task automatic run_window(input int wlen, input int abort_at,
                              input int zmode, input bit hold);
        int         sum;
        int         ph;     // 0 idle, 1 run, 2 drain, 3 done, 4 idle-after-abort
        logic [5:0] exp8, exp2, st8, st2;
        logic [7:0] ecnt8;
        logic [1:0] ecnt2;
        sum   = 0;
        req   = 1'b1;
        len   = wlen[7:0];
        abort = 1'($urandom_range(0, 1));
        det_z = 1'($urandom_range(0, 1));
        @(posedge clock);
        for (int c = 1; c < 600; c++) begin
            @(negedge clock);
            if (wlen == 0)                        ph = (c == 1) ? 3 : 0;
            else if (abort_at != 0 && c == abort_at + 1) ph = 4;
            else if (c <= wlen)                   ph = 1;
            else if (c == wlen + 1)               ph = 2;
            else if (c == wlen + 2)               ph = 3;
            else                                  ph = 0;
            ecnt8 = (sum > 255) ? 8'd255 : sum[7:0];
            ecnt2 = (sum > 3)   ? 2'd3   : sum[1:0];
            exp8 = {ph != 0 && ph != 4, ph == 1, ph == 1 && c == 1, ph == 3, ph == 4, sum > 255};
            exp2 = {ph != 0 && ph != 4, ph == 1, ph == 1 && c == 1, ph == 3, ph == 4, sum > 3};
            st8 = {if8.busy, if8.det_start, if8.ack, if8.done, if8.aborted, if8.overflow};
            st2 = {if2.busy, if2.det_start, if2.ack, if2.done, if2.aborted, if2.overflow};
            n_checks += 4;
            if (st8 !== exp8) begin
                n_fail++;
                $display("FAIL win8 len=%0d c=%0d status got=%b want=%b", wlen, c, st8, exp8);
            end
            if (if8.match_cnt !== ecnt8) begin
                n_fail++;
                $display("FAIL cnt8 len=%0d c=%0d got=%0d want=%0d", wlen, c, if8.match_cnt, ecnt8);
            end
            if (st2 !== exp2) begin
                n_fail++;
                $display("FAIL win2 len=%0d c=%0d status got=%b want=%b", wlen, c, st2, exp2);
            end
            if (if2.match_cnt !== ecnt2) begin
                n_fail++;
                $display("FAIL cnt2 len=%0d c=%0d got=%0d want=%0d", wlen, c, if2.match_cnt, ecnt2);
            end
            if (ph == 0 || ph == 4) break;
            // While busy, req/len are noise that must have no effect.
            req   = hold ? 1'b1 : 1'($urandom_range(0, 1));
            len   = 8'($urandom);
            abort = (ph == 3) ? 1'($urandom_range(0, 1)) : (c == abort_at);
            det_z = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if ((ph == 1 || ph == 2) && det_z) sum++;
            @(posedge clock);
        end
        req   = hold;
        abort = 1'b0;
        det_z = 1'b0;
    endtask

    task automatic test_basic();
        run_window(16, 0, 0, 0);
        run_window(1, 0, 0, 0);
        run_window(2, 0, 1, 0);
        for (int i = 0; i < 4; i++) run_window($urandom_range(3, 20), 0, 0, 0);
    endtask

    task automatic test_zero_len();
        run_window(0, 0, 1, 0);
        run_window(3, 0, 1, 0);
        run_window(0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        run_window(255, 0, 1, 0);
        run_window(5, 0, 2, 0);
        run_window(4, 0, 1, 0);
    endtask

    task automatic test_abort();
        run_window(10, 4, 1, 0);
        run_window(6, 6, 0, 0);
        run_window(6, 7, 1, 0);
        run_window(5, 1, 1, 0);
    endtask

    task automatic test_reset_mid_run();
        logic [5:0] st8, st2;
        req = 1'b1; len = 8'd10; abort = 1'b0; det_z = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0; det_z = 1'b0;
        for (int c = 0; c < 3; c++) begin
            st8 = {if8.busy, if8.det_start, if8.ack, if8.done, if8.aborted, if8.overflow};
            st2 = {if2.busy, if2.det_start, if2.ack, if2.done, if2.aborted, if2.overflow};
            n_checks += 2;
            if (st8 !== 6'b0 || if8.match_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL rstmid8 c=%0d got st=%b cnt=%0d want st=000000 cnt=0", c, st8, if8.match_cnt);
            end
            if (st2 !== 6'b0 || if2.match_cnt !== 2'd0) begin
                n_fail++;
                $display("FAIL rstmid2 c=%0d got st=%b cnt=%0d want st=000000 cnt=0", c, st2, if2.match_cnt);
            end
            @(negedge clock);
        end
        run_window(8, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_window(5, 0, 0, 1);
        run_window(3, 0, 1, 1);
        run_window(0, 0, 0, 1);
        run_window(4, 2, 1, 1);
        run_window(4, 0, 0, 0);
    endtask

    task automatic test_random();
        int wl, ab;
        for (int i = 0; i < 25; i++) begin
            wl = $urandom_range(0, 12);
            ab = (wl != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, wl + 1) : 0;
            run_window(wl, ab, 0, 1'($urandom_range(0, 1)));
        end
        req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_saturation();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_detect_window_ctrl
`default_nettype wire
